csi2tx_dphy_hs_serializer: RTL and testbench
============================================

CSI2TX_DPHY_HS_SERIALIZER -- requirements
Module: csi2tx_dphy_hs_serializer

Interface
REQ-001 SHALL provide parameter: ZERO_BYTES, 3, number of all-zero HS-zero bytes sent before the sync byte (1..15).
REQ-002 SHALL provide parameter: TRAIL_BYTES, 2, number of HS-trail bytes sent after the last data byte (1..15).
REQ-003 SHALL provide port: ddrclkhs  input  1  high-speed DDR clock; all state updates on its rising edge.
REQ-004 SHALL provide port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port: hs_req  input  1  level request to start an HS burst.
REQ-006 SHALL provide port: tx_data  input  8  payload byte.
REQ-007 SHALL provide port: tx_valid  input  1  tx_data valid; low on a sampling edge ends the packet.
REQ-008 SHALL provide port: tx_ready  output  1  one-cycle strobe marking the tx_data sampling edge.
REQ-009 SHALL provide port: ser_bits  output  2  bit pair per ddrclkhs cycle; [0] is rising-half bit, [1] is falling-half bit.
REQ-010 SHALL provide port: hs_active  output  1  high from the first HS-zero bit through the last trail bit.
REQ-011 SHALL provide port: byte_phase  output  2  free-running byte phase, 0..3.

Function
REQ-012 byte_phase SHALL increment every ddrclkhs cycle and wrap 3->0; it is aligned with the divide-by-4 byte clock (phase 0 = byte clock rising).
REQ-013 Byte transmission SHALL be LSB first: phase p drives ser_bits = {byte[2p+1], byte[2p]}.
REQ-014 State transitions and new-byte loads SHALL occur only on the edge leaving phase 3.
REQ-015 FSM states SHALL be IDLE, ZERO, SYNC, DATA and TRAIL.
REQ-016 IDLE: ser_bits=2'b00, hs_active=0; when hs_req=1 on the phase-3 edge, go to ZERO.
REQ-017 ZERO: send ZERO_BYTES bytes of 8'h00 with hs_active=1, then go to SYNC.
REQ-018 SYNC: send 8'hB8 (bit order 0,0,0,1,1,1,0,1).
REQ-019 tx_ready SHALL be 1 only in the phase-3 cycle of a SYNC or DATA byte, and 0 otherwise.
REQ-020 On that phase-3 edge with tx_valid=1, tx_data SHALL be captured and enter or remain in DATA; first bits appear on ser_bits the next cycle (1-cycle latency).
REQ-021 On that phase-3 edge with tx_valid=0, the packet SHALL end: go to TRAIL (empty packet allowed after SYNC).
REQ-022 TRAIL: send TRAIL_BYTES bytes whose every bit equals the inverse of the last transmitted bit (bit 7 of the last data byte, or of 8'hB8 if the packet is empty), then go to IDLE.
REQ-023 hs_req SHALL be ignored outside IDLE; if hs_req is still high on the IDLE phase-3 edge, a new burst SHALL start back-to-back.
REQ-024 tx_data/tx_valid SHALL be ignored when tx_ready=0.

Reset
REQ-025 While rst_n=0: byte_phase=0, state=IDLE, ser_bits=2'b00, tx_ready=0, hs_active=0, internal counters and shift register cleared.
REQ-026 Assertion of rst_n mid-burst SHALL force these values immediately; after deassertion, the first phase-0 cycle SHALL be the first ddrclkhs rising edge.

Configuration
REQ-027 Macro CSI2TX_DPHY_HS_TRAIL_EN defined: TRAIL state behaves per REQ-022.
REQ-028 Macro CSI2TX_DPHY_HS_TRAIL_EN undefined: the end of packet SHALL go directly to IDLE; TRAIL logic is absent; hs_active drops in the cycle after the last data bit.

Structure
REQ-029 Package csi2tx_dphy_pkg SHALL hold the FSM state encoding, SYNC_BYTE=8'hB8 and ZERO_BYTE=8'h00.
REQ-030 Sub-module csi2tx_dphy_byte_phase_cnt SHALL implement the 2-bit phase counter; FSM, counters and shift register stay in the top module.

Verification
REQ-031 Scenario: reset released, hs_req=0 for 40 cycles -> byte_phase cycles 0,1,2,3; ser_bits=00; tx_ready never 1.
REQ-032 Scenario: hs_req=1, packet 8'hA5,8'h3C, defaults -> 12 zero bit-pairs, then B8 pairs 00,10,11,10, A5 pairs 01,01,10,10, 3C pairs 00,11,11,00, then 8 trail pairs of 11 (last bit 0), then IDLE.
REQ-033 Scenario: tx_valid=0 at SYNC phase 3 -> zero data bytes; trail is 00 pairs (B8 bit7=1); total hs_active = (3+1+2)*4 = 24 cycles.
REQ-034 Scenario: rst_n pulsed low during DATA phase 2 -> all outputs 0 on the next sample; after release, IDLE with byte_phase=0.
REQ-035 Scenario: hs_req held high across bursts -> second ZERO starts on the cycle after IDLE's phase-3 edge; no byte is lost or duplicated.
REQ-036 Scenario: build without CSI2TX_DPHY_HS_TRAIL_EN, packet 8'hFF -> hs_active falls directly after the FF pairs; no trail bytes.

Source files
------------

// File: rtl/csi2tx_dphy_pkg.sv
// csi2tx_dphy_pkg
//   Shared definitions for the CSI-2 TX D-PHY HS serializer:
//   the FSM state encoding, the fixed HS-zero and sync byte values,
//   and a helper that picks the bit pair for a byte phase (LSB first).
package csi2tx_dphy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ZERO  = 3'd1,
        ST_SYNC  = 3'd2,
        ST_DATA  = 3'd3,
        ST_TRAIL = 3'd4
    } hs_state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hB8;
    localparam logic [7:0] ZERO_BYTE = 8'h00;

    // Phase p carries {b[2p+1], b[2p]}: bit 0 of the pair goes out in the
    // rising half of ddrclkhs, bit 1 in the falling half.
    function automatic logic [1:0] bit_pair(input logic [7:0] b, input logic [1:0] p);
        logic [1:0] r;
        case (p)
            2'd0:    r = b[1:0];
            2'd1:    r = b[3:2];
            2'd2:    r = b[5:4];
            default: r = b[7:6];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/csi2tx_dphy_byte_phase_cnt.sv
// csi2tx_dphy_byte_phase_cnt
//   Free-running 2-bit byte phase counter (divide-by-4 byte clock).
//   Ports:
//     ddrclkhs   in   HS DDR clock
//     rst_n      in   async active-low reset (phase forced to 0)
//     phase      out  current byte phase 0..3
//     phase_last out  high in phase 3, i.e. on the cycle whose closing
//                     edge is the byte boundary
module csi2tx_dphy_byte_phase_cnt (
    input  logic       ddrclkhs,
    input  logic       rst_n,
    output logic [1:0] phase,
    output logic       phase_last
);

    logic [1:0] phase_q;
    logic [1:0] phase_d;

    always_comb begin
        phase_d = phase_q + 2'd1;
    end

    always_ff @(posedge ddrclkhs or negedge rst_n) begin
        if (!rst_n) phase_q <= 2'd0;
        else        phase_q <= phase_d;
    end

    assign phase      = phase_q;
    assign phase_last = (phase_q == 2'd3);

endmodule

// File: rtl/csi2tx_dphy_hs_serializer.sv
// csi2tx_dphy_hs_serializer
//   D-PHY HS burst serializer: HS-zero bytes, sync byte 8'hB8, payload,
//   then optional HS-trail, emitted LSB first as two bits per ddrclkhs.
//   Build option: define CSI2TX_DPHY_HS_TRAIL_EN to include the HS-trail
//   state; without it the burst ends directly after the last data byte.
//   Ports:
//     ddrclkhs   in   HS DDR clock, all state on rising edge
//     rst_n      in   async active-low reset
//     hs_req     in   level request to start a burst (sampled in IDLE only)
//     tx_data    in   payload byte
//     tx_valid   in   payload valid; low at a sampling edge ends the packet
//     tx_ready   out  strobe marking the tx_data sampling edge
//     ser_bits   out  {falling-half bit, rising-half bit}
//     hs_active  out  high for every cycle of the burst
//     byte_phase out  free-running byte phase 0..3
module csi2tx_dphy_hs_serializer
    import csi2tx_dphy_pkg::*;
#(
    parameter int unsigned ZERO_BYTES  = 3,
    parameter int unsigned TRAIL_BYTES = 2
) (
    input  logic       ddrclkhs,
    input  logic       rst_n,
    input  logic       hs_req,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [1:0] ser_bits,
    output logic       hs_active,
    output logic [1:0] byte_phase
);

    // One byte counter serves both ZERO and TRAIL; it holds bytes-remaining-minus-one.
    localparam int unsigned CNT_MAX = (ZERO_BYTES > TRAIL_BYTES) ? ZERO_BYTES : TRAIL_BYTES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] ZERO_LAST  = CNT_W'(ZERO_BYTES - 1);
    localparam logic [CNT_W-1:0] TRAIL_LAST = CNT_W'(TRAIL_BYTES - 1);

    logic [1:0] phase;
    logic       phase_last;

    hs_state_e        state_q, state_d;
    logic [7:0]       byte_q,  byte_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    csi2tx_dphy_byte_phase_cnt u_phase (
        .ddrclkhs   (ddrclkhs),
        .rst_n      (rst_n),
        .phase      (phase),
        .phase_last (phase_last)
    );

    // All transitions and byte loads happen on the edge leaving phase 3, so
    // a newly loaded byte starts at phase 0 in the following cycle.
    always_comb begin
        state_d  = state_q;
        byte_d   = byte_q;
        cnt_d    = cnt_q;
        tx_ready = 1'b0;
        if (phase_last) begin
            case (state_q)
                ST_IDLE: begin
                    if (hs_req) begin
                        state_d = ST_ZERO;
                        byte_d  = ZERO_BYTE;
                        cnt_d   = ZERO_LAST;
                    end
                end
                ST_ZERO: begin
                    if (cnt_q == '0) begin
                        state_d = ST_SYNC;
                        byte_d  = SYNC_BYTE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_SYNC, ST_DATA: begin
                    tx_ready = 1'b1;
                    if (tx_valid) begin
                        state_d = ST_DATA;
                        byte_d  = tx_data;
                    end else begin
`ifdef CSI2TX_DPHY_HS_TRAIL_EN
                        // Trail level is the inverse of the last bit sent (bit 7).
                        state_d = ST_TRAIL;
                        byte_d  = {8{~byte_q[7]}};
                        cnt_d   = TRAIL_LAST;
`else
                        state_d = ST_IDLE;
                        byte_d  = ZERO_BYTE;
`endif
                    end
                end
`ifdef CSI2TX_DPHY_HS_TRAIL_EN
                ST_TRAIL: begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                        byte_d  = ZERO_BYTE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                    byte_d  = ZERO_BYTE;
                end
            endcase
        end
    end

    always_ff @(posedge ddrclkhs or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            byte_q  <= 8'h00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hs_active  = (state_q != ST_IDLE);
    assign ser_bits   = hs_active ? bit_pair(byte_q, phase) : 2'b00;
    assign byte_phase = phase;

endmodule

// File: tb/tb_csi2tx_dphy_hs_serializer.sv
// Scoreboard bench for csi2tx_dphy_hs_serializer: stimulus pushes the
// expected bit pairs of each burst into a queue, a monitor pops one pair
// per hs_active cycle and also tracks byte_phase against a small counter model.
module tb_csi2tx_dphy_hs_serializer;

    localparam int ZB = 3;
    localparam int TB = 2;

    logic       ddrclkhs = 1'b0;
    logic       rst_n    = 1'b0;
    logic       hs_req   = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [1:0] ser_bits;
    logic       hs_active;
    logic [1:0] byte_phase;

    csi2tx_dphy_hs_serializer #(.ZERO_BYTES(ZB), .TRAIL_BYTES(TB)) dut (
        .ddrclkhs   (ddrclkhs),
        .rst_n      (rst_n),
        .hs_req     (hs_req),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ser_bits   (ser_bits),
        .hs_active  (hs_active),
        .byte_phase (byte_phase)
    );

    always #5 ddrclkhs = ~ddrclkhs;

    int tests = 0;
    int fails = 0;

    logic [1:0] exp_q[$];
    logic [1:0] mon_exp;
    int         exp_len;
    int         act_cnt;
    logic [1:0] exp_phase;
    logic [7:0] pkt[8];
    int         pkt_n;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference phase counter.
    always @(posedge ddrclkhs or negedge rst_n) begin
        if (!rst_n) exp_phase <= 2'd0;
        else        exp_phase <= exp_phase + 2'd1;
    end

    // Monitor
    always @(negedge ddrclkhs) begin
        if (!rst_n) begin
            chk("rst_outs", {25'd0, ser_bits, tx_ready, hs_active, byte_phase}, 32'd0);
        end else begin
            chk("byte_phase", byte_phase, exp_phase);
            if (hs_active) begin
                act_cnt++;
                if (exp_q.size() == 0) begin
                    chk("extra_active", hs_active, 0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("ser_bits", ser_bits, mon_exp);
                end
            end else begin
                chk("idle_ser", ser_bits, 0);
                chk("idle_ready", tx_ready, 0);
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        for (int p = 0; p < 4; p++) begin
            exp_q.push_back({b[2*p+1], b[2*p]});
            exp_len++;
        end
    endtask

    task automatic push_burst();
        logic l;
        exp_len = 0;
        act_cnt = 0;
        for (int i = 0; i < ZB; i++) push_byte(8'h00);
        push_byte(8'hB8);
        for (int i = 0; i < pkt_n; i++) push_byte(pkt[i]);
`ifdef CSI2TX_DPHY_HS_TRAIL_EN
        l = (pkt_n > 0) ? pkt[pkt_n-1][7] : 1'b1;
        for (int i = 0; i < TB; i++) push_byte({8{~l}});
`else
        l = 1'b0;
`endif
    endtask

    task automatic tick();
        @(negedge ddrclkhs);
        #1;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!tx_ready && k < 200) begin tick(); k++; end
        chk("ready_seen", tx_ready, 1);
    endtask

    task automatic wait_active();
        int k = 0;
        while (!hs_active && k < 50) begin tick(); k++; end
        chk("hs_start", hs_active, 1);
    endtask

    // Feed pkt then an end-of-packet edge; garbage with tx_valid=1 is driven
    // outside the sampling edges and must be ignored.
    task automatic feed();
        for (int i = 0; i <= pkt_n; i++) begin
            wait_ready();
            tx_valid = (i < pkt_n);
            tx_data  = (i < pkt_n) ? pkt[i] : 8'hEE;
            tick();
            tx_valid = 1'b1;
            tx_data  = 8'hC3;
        end
    endtask

    task automatic wait_drain();
        int k = 0;
        while (exp_q.size() > 0 && k < 600) begin tick(); k++; end
        chk("drain", exp_q.size(), 0);
        tick();
        chk("hs_fall", hs_active, 0);
        chk("active_len", act_cnt, exp_len);
    endtask

    task automatic run_burst();
        push_burst();
        hs_req = 1'b1;
        wait_active();
        hs_req = 1'b0;
        feed();
        wait_drain();
    endtask

    initial begin
        int g;
        int k;
        // Reset and idle
        repeat (3) tick();
        rst_n = 1'b1;
        chk("rel_phase0", byte_phase, 0);
        repeat (40) tick();

        // Two-byte packet
        pkt[0] = 8'hA5; pkt[1] = 8'h3C; pkt_n = 2;
        run_burst();

        // Empty packet
        pkt_n = 0;
        run_burst();
`ifdef CSI2TX_DPHY_HS_TRAIL_EN
        chk("empty_len", act_cnt, (ZB + 1 + TB) * 4);
`else
        chk("empty_len", act_cnt, (ZB + 1) * 4);
`endif

        // Single FF byte
        pkt[0] = 8'hFF; pkt_n = 1;
        run_burst();

        // Back-to-back bursts with hs_req held
        pkt[0] = 8'h12; pkt_n = 1;
        push_burst();
        hs_req = 1'b1;
        wait_active();
        feed();
        k = 0;
        while (hs_active && k < 200) begin tick(); k++; end
        chk("b2b_drain1", exp_q.size(), 0);
        chk("b2b_len1", act_cnt, exp_len);
        pkt[0] = 8'h80; pkt[1] = 8'h01; pkt_n = 2;
        push_burst();
        g = 1;
        while (!hs_active && g < 20) begin tick(); if (!hs_active) g++; end
        chk("b2b_gap", g, 4);
        hs_req = 1'b0;
        feed();
        wait_drain();

        // Reset mid-DATA at phase 2
        pkt[0] = 8'h11; pkt[1] = 8'h22; pkt_n = 2;
        push_burst();
        hs_req = 1'b1;
        wait_active();
        hs_req = 1'b0;
        wait_ready();
        tx_valid = 1'b1; tx_data = 8'h11;
        tick(); tick(); tick();
        chk("pre_rst_phase", byte_phase, 2);
        chk("pre_rst_active", hs_active, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async", {28'd0, ser_bits, tx_ready, hs_active}, 0);
        chk("rst_phase", byte_phase, 0);
        exp_q.delete();
        tx_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_rel_phase", byte_phase, 0);
        tick();
        chk("rst_rel_idle", hs_active, 0);
        repeat (8) tick();

        // Recovery burst
        pkt[0] = 8'h5A; pkt_n = 1;
        run_burst();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
